// File: rtl/tl45_wb_sram16.sv
// tl45_wb_sram16: pipelined-Wishbone slave that splits 32-bit accesses into two 16-bit async SRAM phases.
module tl45_wb_sram16 #(
    parameter int AW = 18,
    parameter int WAIT = 1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wb_cyc,
    input  logic          i_wb_stb,
    input  logic          i_wb_we,
    input  logic [29:0]   i_wb_addr,
    input  logic [31:0]   i_wb_data,
    input  logic [3:0]    i_wb_sel,
    output logic          o_wb_ack,
    output logic          o_wb_stall,
    output logic          o_wb_err,
    output logic [31:0]   o_wb_data,
    output logic [AW:0]   o_sram_addr,
    output logic          o_sram_ce_n,
    output logic          o_sram_oe_n,
    output logic          o_sram_we_n,
    output logic          o_sram_lb_n,
    output logic          o_sram_ub_n,
    output logic [15:0]   o_sram_dq,
    output logic          o_sram_dq_oe,
    input  logic [15:0]   i_sram_dq
);
    typedef enum logic [2:0] {IDLE, LO, HI, ACK, ERR} state_t;
    state_t state, state_n;
    logic [2:0] cnt;
    logic [AW-1:0] addr;
    logic [31:0] data;
    logic [3:0] sel;
    logic we, accept, legal, phase, last, hi;
    assign accept = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign legal = (i_wb_addr >> AW) == 30'd0;
    // Dropping cyc releases the pads immediately, not just from the next cycle.
    assign phase = (state == LO || state == HI) && i_wb_cyc;
    assign hi = state == HI;
    assign last = cnt == 3'(WAIT);
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = !legal ? ERR : |i_wb_sel[1:0] ? LO : |i_wb_sel[3:2] ? HI : ACK;
            LO: if (last) state_n = |sel[3:2] ? HI : ACK;
            HI: if (last) state_n = ACK;
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !i_wb_cyc) state_n = IDLE;
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
            cnt <= 3'd0;
        end else begin
            state <= state_n;
            cnt <= (phase && state_n == state) ? cnt + 3'd1 : 3'd0;
        end
    end
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            addr <= '0;
            data <= '0;
            sel <= '0;
            we <= 1'b0;
            o_wb_data <= '0;
        end else begin
            if (accept) begin
                addr <= i_wb_addr[AW-1:0];
                data <= i_wb_data;
                sel <= i_wb_sel;
                we <= i_wb_we;
                if (!i_wb_we && legal) o_wb_data <= '0;
            end
            if (phase && !we && last && !hi)
                o_wb_data[15:0] <= {sel[1] ? i_sram_dq[15:8] : 8'h0, sel[0] ? i_sram_dq[7:0] : 8'h0};
            if (phase && !we && last && hi)
                o_wb_data[31:16] <= {sel[3] ? i_sram_dq[15:8] : 8'h0, sel[2] ? i_sram_dq[7:0] : 8'h0};
        end
    end
    assign o_wb_stall = state != IDLE;
    assign o_wb_ack = state == ACK;
    assign o_wb_err = state == ERR;
    assign o_sram_addr = phase ? {addr, hi} : '0;
    assign o_sram_ce_n = !phase;
    assign o_sram_oe_n = !(phase && !we);
    // The final cycle of a write phase holds address and data with we_n high.
    assign o_sram_we_n = !(phase && we && !last);
    assign o_sram_lb_n = !(phase && (hi ? sel[2] : sel[0]));
    assign o_sram_ub_n = !(phase && (hi ? sel[3] : sel[1]));
    assign o_sram_dq = phase ? (hi ? data[31:16] : data[15:0]) : 16'h0;
    assign o_sram_dq_oe = phase && we;
endmodule

// File: tb/tb_tl45_wb_sram16.sv
// tb_tl45_wb_sram16: table-driven Wishbone transactions against a byte-lane SRAM model,
// plus hand sequences for cycle drop, stalled strobes and mid-transaction reset.
module tb_tl45_wb_sram16;
    localparam int AW = 18;
    logic i_clk = 0, i_reset = 1;
    logic i_wb_cyc = 0, i_wb_stb = 0, i_wb_we = 0;
    logic [29:0] i_wb_addr = 0;
    logic [31:0] i_wb_data = 0;
    logic [3:0] i_wb_sel = 0;
    logic o_wb_ack, o_wb_stall, o_wb_err;
    logic [31:0] o_wb_data;
    logic [AW:0] o_sram_addr;
    logic o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe;
    logic [15:0] o_sram_dq, i_sram_dq;
    logic [15:0] mem [0:31];
    int n_cmp = 0, n_bad = 0;

    tl45_wb_sram16 #(.AW(AW), .WAIT(1)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_wb_cyc(i_wb_cyc), .i_wb_stb(i_wb_stb),
        .i_wb_we(i_wb_we), .i_wb_addr(i_wb_addr), .i_wb_data(i_wb_data), .i_wb_sel(i_wb_sel),
        .o_wb_ack(o_wb_ack), .o_wb_stall(o_wb_stall), .o_wb_err(o_wb_err), .o_wb_data(o_wb_data),
        .o_sram_addr(o_sram_addr), .o_sram_ce_n(o_sram_ce_n), .o_sram_oe_n(o_sram_oe_n),
        .o_sram_we_n(o_sram_we_n), .o_sram_lb_n(o_sram_lb_n), .o_sram_ub_n(o_sram_ub_n),
        .o_sram_dq(o_sram_dq), .o_sram_dq_oe(o_sram_dq_oe), .i_sram_dq(i_sram_dq)
    );

    always #5 i_clk = ~i_clk;

    assign i_sram_dq = (!o_sram_ce_n && !o_sram_oe_n) ? mem[o_sram_addr[4:0]] : 16'hDEAD;

    always @(posedge i_clk) begin
        if (!o_sram_ce_n && !o_sram_we_n) begin
            if (!o_sram_lb_n) mem[o_sram_addr[4:0]][7:0] <= o_sram_dq[7:0];
            if (!o_sram_ub_n) mem[o_sram_addr[4:0]][15:8] <= o_sram_dq[15:8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issues one request and watches the pads until ack/err or a 20-cycle bound.
    task automatic xact(input logic we, input logic [29:0] a, input logic [31:0] d, input logic [3:0] s,
                        output int done, output logic was_err, output int ce_c, output int we_c,
                        output int bad, output logic [31:0] rd);
        done = 0; was_err = 0; ce_c = 0; we_c = 0; bad = 0; rd = 0;
        @(negedge i_clk);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = we; i_wb_addr = a; i_wb_data = d; i_wb_sel = s;
        @(negedge i_clk);
        i_wb_stb = 0;
        for (int n = 1; n <= 20; n++) begin
            if (!o_sram_ce_n) begin
                ce_c++;
                if (!o_sram_we_n) we_c++;
                if (o_sram_addr[AW:1] !== a[AW-1:0]) bad++;
                if (o_sram_lb_n !== !s[o_sram_addr[0] ? 2 : 0]) bad++;
                if (o_sram_ub_n !== !s[o_sram_addr[0] ? 3 : 1]) bad++;
                if (o_sram_dq_oe !== we || o_sram_oe_n !== we) bad++;
                if (we && o_sram_dq !== (o_sram_addr[0] ? d[31:16] : d[15:0])) bad++;
            end
            if (o_wb_ack || o_wb_err) begin
                done = n; was_err = o_wb_err; rd = o_wb_data;
                break;
            end
            @(negedge i_clk);
        end
        i_wb_cyc = 0;
    endtask

    typedef struct {
        logic we; logic [29:0] addr; logic [31:0] data; logic [3:0] sel;
        int done; logic err; int ce; int wec; logic [31:0] rd;
    } vec_t;
    vec_t v [12];

    initial begin
        int done, ce_c, we_c, bad, acks;
        logic was_err;
        logic [31:0] rd;
        for (int i = 0; i < 32; i++) mem[i] = 16'h0;
        v[0]  = '{1, 30'd5,       32'hA1B2C3D4, 4'hF, 5, 0, 4, 2, 32'h0};
        v[1]  = '{0, 30'd5,       32'h0,        4'hF, 5, 0, 4, 0, 32'hA1B2C3D4};
        v[2]  = '{0, 30'd5,       32'h0,        4'h4, 3, 0, 2, 0, 32'h00B20000};
        v[3]  = '{0, 30'd5,       32'h0,        4'h0, 1, 0, 0, 0, 32'h0};
        v[4]  = '{1, 30'h40000,   32'h12345678, 4'hF, 1, 1, 0, 0, 32'h0};
        v[5]  = '{1, 30'd7,       32'h11223344, 4'h3, 3, 0, 2, 1, 32'h0};
        v[6]  = '{0, 30'd7,       32'h0,        4'h2, 3, 0, 2, 0, 32'h00003300};
        v[7]  = '{1, 30'd7,       32'h55667788, 4'h8, 3, 0, 2, 1, 32'h0};
        v[8]  = '{0, 30'd7,       32'h0,        4'hF, 5, 0, 4, 0, 32'h55003344};
        v[9]  = '{1, 30'h3FFFF,   32'hDEADBEEF, 4'hF, 5, 0, 4, 2, 32'h0};
        v[10] = '{0, 30'h3FFFF,   32'h0,        4'hF, 5, 0, 4, 0, 32'hDEADBEEF};
        v[11] = '{0, 30'h3FFFFFFF, 32'h0,       4'hF, 1, 1, 0, 0, 32'h0};

        #2;
        chk("rst_ack", {o_wb_ack, o_wb_err, o_wb_stall}, 0);
        chk("rst_ctl", {o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 6'b111110);
        chk("rst_data", o_wb_data, 0);
        chk("rst_addr", 32'(o_sram_addr), 0);
        @(negedge i_clk); @(negedge i_clk);
        i_reset = 0;

        for (int i = 0; i < 12; i++) begin
            xact(v[i].we, v[i].addr, v[i].data, v[i].sel, done, was_err, ce_c, we_c, bad, rd);
            chk($sformatf("v%0d_latency", i), done, v[i].done);
            chk($sformatf("v%0d_err", i), 32'(was_err), 32'(v[i].err));
            chk($sformatf("v%0d_ce_cycles", i), ce_c, v[i].ce);
            chk($sformatf("v%0d_we_cycles", i), we_c, v[i].wec);
            chk($sformatf("v%0d_pad_checks", i), bad, 0);
            if (!v[i].we && !v[i].err) chk($sformatf("v%0d_rdata", i), rd, v[i].rd);
        end

        // Drop cyc during the HI phase of a write: no ack, pads released.
        @(negedge i_clk);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 1; i_wb_addr = 30'd9; i_wb_data = 32'hCAFEF00D; i_wb_sel = 4'hF;
        @(negedge i_clk); i_wb_stb = 0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("drop_in_hi", {o_sram_ce_n, 18'(o_sram_addr)}, {1'b0, 18'd19});
        i_wb_cyc = 0;
        @(negedge i_clk);
        chk("drop_stall", o_wb_stall, 0);
        chk("drop_pads", {o_sram_ce_n, o_sram_we_n, o_sram_dq_oe}, 3'b110);
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            acks += int'(o_wb_ack) + int'(o_wb_err);
            @(negedge i_clk);
        end
        chk("drop_no_ack", acks, 0);

        // Strobe held while stalled is ignored: exactly one ack for a held-strobe read.
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 30'd5; i_wb_sel = 4'hF;
        acks = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge i_clk);
            if (n == 3) i_wb_stb = 0;
            acks += int'(o_wb_ack);
        end
        i_wb_cyc = 0;
        chk("stall_one_ack", acks, 1);

        // Reset during the LO phase of a read aborts it.
        @(negedge i_clk);
        i_wb_cyc = 1; i_wb_stb = 1; i_wb_we = 0; i_wb_addr = 30'd5; i_wb_sel = 4'hF;
        @(negedge i_clk); i_wb_stb = 0;
        chk("pre_rst_lo", {o_sram_ce_n, 18'(o_sram_addr)}, {1'b0, 18'd10});
        i_reset = 1;
        #1;
        chk("mid_rst_ctl", {o_sram_ce_n, o_sram_oe_n, o_sram_lb_n, o_sram_ub_n, o_sram_dq_oe}, 5'b11110);
        chk("mid_rst_wb", {o_wb_ack, o_wb_err, o_wb_stall}, 0);
        chk("mid_rst_addr", 32'(o_sram_addr), 0);
        @(negedge i_clk);
        i_reset = 0;
        acks = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge i_clk);
            acks += int'(o_wb_ack);
        end
        i_wb_cyc = 0;
        chk("rst_no_ack", acks, 0);
        xact(0, 30'd5, 32'h0, 4'hF, done, was_err, ce_c, we_c, bad, rd);
        chk("post_rst_latency", done, 5);
        chk("post_rst_rdata", rd, 32'hA1B2C3D4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/tl45_wb_sram16.md
TL45_WB_SRAM16 -- requirements
Module: tl45_wb_sram16

Interface
REQ-001 SHALL have parameter AW, default 18, meaning the word-address width of attached memory (16-bit SRAM has AW+1 address bits).
REQ-002 SHALL have parameter WAIT, default 1, legal range 1..7, meaning the number of cycles per SRAM half-word phase minus one.
REQ-003 SHALL have one clock; reset is asynchronous and active-high; ports are i_clk and i_reset.
REQ-004 i_clk  in  1  system clock.
REQ-005 i_reset  in  1  asynchronous active-high reset.
REQ-006 i_wb_cyc, i_wb_stb, i_wb_we  in  1 each  pipelined-Wishbone cycle, strobe and write-enable from bus initiator.
REQ-007 i_wb_addr  in  30  word address.
REQ-008 i_wb_data  in  32  write data.
REQ-009 i_wb_sel  in  4  byte lane selects; bit0 = bits 7:0.
REQ-010 o_wb_ack  out  1  single-cycle completion.
REQ-011 o_wb_stall  out  1  request not accepted this cycle.
REQ-012 o_wb_err  out  1  single-cycle error completion.
REQ-013 o_wb_data  out  32  read data; valid with o_wb_ack.
REQ-014 o_sram_addr  out  AW+1  half-word address.
REQ-015 o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  active-low SRAM controls.
REQ-016 o_sram_dq  out  16  write data to SRAM pads.
REQ-017 o_sram_dq_oe  out  1  pad output enable, high drives o_sram_dq.
REQ-018 i_sram_dq  in  16  read data from SRAM pads.

Function
REQ-019 States SHALL be IDLE, LO, HI, ACK, ERR.
REQ-020 o_wb_stall SHALL be 0 in IDLE and 1 in all other states.
REQ-021 Accept SHALL occur when i_wb_cyc && i_wb_stb && !o_wb_stall; addr, we, data and sel are latched on accept.
REQ-022 On accept with i_wb_addr[29:AW] != 0, next state SHALL be ERR; ERR pulses o_wb_err for one cycle, then goes IDLE, with no SRAM activity.
REQ-023 On a legal accept, next state SHALL be LO if sel[1:0]!=0, else HI if sel[3:2]!=0, else ACK (sel==0: no SRAM activity).
REQ-024 Each LO/HI phase SHALL last exactly WAIT+1 cycles, counted by an internal counter that resets at phase entry.
REQ-025 LO phase SHALL use o_sram_addr={addr[AW-1:0],0}, lb_n=!sel[0], ub_n=!sel[1], o_sram_dq=data[15:0].
REQ-026 HI phase SHALL use o_sram_addr={addr[AW-1:0],1}, lb_n=!sel[2], ub_n=!sel[3], o_sram_dq=data[31:16].
REQ-027 After LO, next state SHALL be HI if sel[3:2]!=0, else ACK.
REQ-028 During a phase, ce_n SHALL be 0; for reads oe_n=0, we_n=1, dq_oe=0.
REQ-029 Write phases SHALL have oe_n=1 and dq_oe=1 all cycles, with we_n=0 in phase cycles 0..WAIT-1 and we_n=1 in the last cycle (data/address hold).
REQ-030 Reads SHALL sample i_sram_dq on the last phase cycle into the matching half of o_wb_data; deselected byte lanes read 0.
REQ-031 ACK SHALL pulse o_wb_ack for one cycle, then go IDLE; o_wb_data is updated only by reads and holds otherwise.
REQ-032 Outside LO/HI, all SRAM controls SHALL be 1 and dq_oe 0.
REQ-033 Full-word latency SHALL be: accept at cycle 0, ack at cycle 2*(WAIT+1)+1; half-word at cycle WAIT+2; sel==0 at cycle 1.
REQ-034 If i_wb_cyc is 0 in any non-IDLE state, the block SHALL go IDLE next cycle with no ack/err, and SRAM controls are released that cycle.
REQ-035 i_wb_stb while stalled SHALL be ignored (no queuing).

Reset
REQ-036 On i_reset, immediately: state IDLE, counter 0, o_wb_ack/o_wb_err/o_wb_stall = 0, o_wb_data = 0, o_sram_addr = 0, o_sram_dq = 0, all active-low controls = 1, dq_oe = 0.
REQ-037 Reset asserted mid-transaction SHALL abort it; no ack follows reset release.

Verification
REQ-038 WAIT=1, write addr 5, data 0xA1B2C3D4, sel 0xF -> LO at sram addr 10 drives 0xC3D4, HI at addr 11 drives 0xA1B2, we_n low 1 cycle per phase, ack at cycle 5.
REQ-039 Read addr 5 with SRAM model returning 0xC3D4/0xA1B2 -> o_wb_data=0xA1B2C3D4 with ack at cycle 5.
REQ-040 Read sel 0x4 at addr 5 -> HI phase only, ub_n=1, lb_n=0, ack at cycle 3, o_wb_data[23:16]=0xB2, other bits 0.
REQ-041 Access to addr 0x0004_0000 (AW=18) -> err at cycle 1, no ack, ce_n stays 1.
REQ-042 i_wb_cyc dropped in HI phase of write -> next cycle IDLE, we_n=1, dq_oe=0, stall=0, no ack.
REQ-043 i_reset asserted during LO read -> outputs at reset values same cycle; new read after release completes normally.
